// File: rtl/pin_record_pkg.sv
// Shared widths, record layouts and FSM encoding for the pin record decoder.
package pin_record_pkg;

    localparam int INST_W_DEF = 16;
    localparam int PORT_W_DEF = 8;
    localparam int NET_W_DEF  = 16;
    localparam int BIT_W_DEF  = 8;

    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [PORT_W_DEF-1:0] port;
        logic [NET_W_DEF-1:0]  net;
        logic [BIT_W_DEF-1:0]  msb;
        logic [BIT_W_DEF-1:0]  lsb;
        logic                  last;
    } seg_rec_t;

    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [PORT_W_DEF-1:0] port;
        logic [NET_W_DEF-1:0]  net;
        logic [BIT_W_DEF-1:0]  nbit;
        logic [BIT_W_DEF-1:0]  pbit;
        logic                  last;
    } pin_evt_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } dec_state_t;

endpackage

// File: rtl/pin_record_decoder.sv
// Expands net-range segment records into one pin event per net bit, msb first.
// Optional counters: define PIN_RECORD_DECODER_STATS_EN to add stat_seg_cnt/stat_bit_cnt.
module pin_record_decoder
    import pin_record_pkg::*;
#(
    parameter int INST_W = INST_W_DEF,
    parameter int PORT_W = PORT_W_DEF,
    parameter int NET_W  = NET_W_DEF,
    parameter int BIT_W  = BIT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PORT_W-1:0] in_port,
    input  logic [NET_W-1:0]  in_net,
    input  logic [BIT_W-1:0]  in_msb,
    input  logic [BIT_W-1:0]  in_lsb,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PORT_W-1:0] out_port,
    output logic [NET_W-1:0]  out_net,
    output logic [BIT_W-1:0]  out_nbit,
    output logic [BIT_W-1:0]  out_pbit,
    output logic              out_last
`ifdef PIN_RECORD_DECODER_STATS_EN
    ,
    output logic [31:0]       stat_seg_cnt,
    output logic [31:0]       stat_bit_cnt
`endif
);

    dec_state_t       state_q, state_d;
    logic [BIT_W-1:0] end_bit_q;
    logic             step_up_q;
    logic             seg_last_q;
    logic             final_bit;
    logic             in_fire;
    logic             out_fire;

    assign out_valid = (state_q == ST_EXPAND);
    assign final_bit = (out_nbit == end_bit_q);
    assign out_last  = out_valid && seg_last_q && final_bit;
    // Accepting on the final-bit handshake lets segments follow with no bubble.
    assign in_ready  = rst_n && ((state_q == ST_IDLE) || (final_bit && out_ready));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (in_fire) state_d = ST_EXPAND;
            ST_EXPAND: if (out_fire && final_bit && !in_fire) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // out_pbit doubles as the running port-bit counter; in IDLE it holds the next index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_inst   <= '0;
            out_port   <= '0;
            out_net    <= '0;
            out_nbit   <= '0;
            out_pbit   <= '0;
            end_bit_q  <= '0;
            step_up_q  <= 1'b0;
            seg_last_q <= 1'b0;
        end else begin
            if (out_fire)
                out_pbit <= out_last ? '0 : out_pbit + 1'b1;
            if (in_fire) begin
                out_inst   <= in_inst;
                out_port   <= in_port;
                out_net    <= in_net;
                out_nbit   <= in_msb;
                end_bit_q  <= in_lsb;
                step_up_q  <= (in_msb < in_lsb);
                seg_last_q <= in_last;
            end else if (out_fire && !final_bit) begin
                out_nbit <= step_up_q ? out_nbit + 1'b1 : out_nbit - 1'b1;
            end
        end
    end

`ifdef PIN_RECORD_DECODER_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_seg_cnt <= '0;
            stat_bit_cnt <= '0;
        end else begin
            if (in_fire)  stat_seg_cnt <= sat_inc(stat_seg_cnt);
            if (out_fire) stat_bit_cnt <= sat_inc(stat_bit_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_pin_record_decoder.sv
// Randomized and directed bench for pin_record_decoder against a queue-based expansion model.
module tb_pin_record_decoder;
    import pin_record_pkg::*;

    localparam int INST_W = INST_W_DEF;
    localparam int PORT_W = PORT_W_DEF;
    localparam int NET_W  = NET_W_DEF;
    localparam int BIT_W  = BIT_W_DEF;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [PORT_W-1:0] in_port;
    logic [NET_W-1:0]  in_net;
    logic [BIT_W-1:0]  in_msb;
    logic [BIT_W-1:0]  in_lsb;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PORT_W-1:0] out_port;
    logic [NET_W-1:0]  out_net;
    logic [BIT_W-1:0]  out_nbit;
    logic [BIT_W-1:0]  out_pbit;
    logic              out_last;
`ifdef PIN_RECORD_DECODER_STATS_EN
    logic [31:0]       stat_seg_cnt;
    logic [31:0]       stat_bit_cnt;
`endif

    pin_record_decoder #(
        .INST_W(INST_W), .PORT_W(PORT_W), .NET_W(NET_W), .BIT_W(BIT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_port(in_port), .in_net(in_net),
        .in_msb(in_msb), .in_lsb(in_lsb), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_port(out_port), .out_net(out_net),
        .out_nbit(out_nbit), .out_pbit(out_pbit), .out_last(out_last)
`ifdef PIN_RECORD_DECODER_STATS_EN
        , .stat_seg_cnt(stat_seg_cnt), .stat_bit_cnt(stat_bit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: every accepted segment is unrolled into its full event list.
    pin_evt_t         exp_q[$];
    logic [BIT_W-1:0] m_pbit   = '0;
    int               evt_cnt  = 0;
    bit               rst_seen = 0;
    int               rdy_mode = 0;

    task automatic model_accept(input seg_rec_t s);
        int d, n;
        pin_evt_t e;
        d = int'(s.msb) - int'(s.lsb);
        n = ((d < 0) ? -d : d) + 1;
        for (int i = 0; i < n; i++) begin
            e.inst = s.inst;
            e.port = s.port;
            e.net  = s.net;
            e.nbit = (d >= 0) ? BIT_W'(int'(s.msb) - i) : BIT_W'(int'(s.msb) + i);
            e.pbit = m_pbit;
            e.last = s.last && (i == n - 1);
            exp_q.push_back(e);
            m_pbit = e.last ? '0 : m_pbit + 1'b1;
        end
    endtask

    always @(negedge clk) begin
        seg_rec_t s;
        if (!rst_n) begin
            chk("rst_in_ready", in_ready, 0);
            if (rst_seen) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_out_nbit", out_nbit, 0);
                chk("rst_out_pbit", out_pbit, 0);
                chk("rst_out_net", out_net, 0);
            end
            rst_seen = 1;
            exp_q.delete();
            m_pbit = '0;
        end else begin
            rst_seen = 0;
            chk("in_ready", in_ready,
                (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                chk("out_inst", out_inst, exp_q[0].inst);
                chk("out_port", out_port, exp_q[0].port);
                chk("out_net",  out_net,  exp_q[0].net);
                chk("out_nbit", out_nbit, exp_q[0].nbit);
                chk("out_pbit", out_pbit, exp_q[0].pbit);
                chk("out_last", out_last, exp_q[0].last);
            end else begin
                chk("idle_out_last", out_last, 0);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                evt_cnt++;
            end
            if (in_valid && in_ready) begin
                s.inst = in_inst; s.port = in_port; s.net = in_net;
                s.msb = in_msb; s.lsb = in_lsb; s.last = in_last;
                model_accept(s);
            end
        end
    end

    // out_ready pattern: 0 = always, 1 = random, 2 = repeating 1,0,0.
    initial begin
        int phase;
        phase = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_ready = ($urandom_range(0, 3) != 0);
                2:       begin out_ready = (phase == 0); phase = (phase + 1) % 3; end
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_seg(input int inst, input int port, input int net,
                            input int msb, input int lsb, input bit last);
        bit acc;
        int guard;
        in_inst = INST_W'(inst); in_port = PORT_W'(port); in_net = NET_W'(net);
        in_msb = BIT_W'(msb); in_lsb = BIT_W'(lsb); in_last = last;
        in_valid = 1'b1;
        acc = 0;
        guard = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            step();
            guard++;
            if (!acc && guard > 2000) begin
                chk("accept_timeout", 0, 1);
                acc = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        in_valid = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 5000) begin
            step();
            guard++;
        end
        if (guard >= 5000) chk("drain_timeout", 0, 1);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int base, guard;
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_port = '0; in_net = '0;
        in_msb = '0; in_lsb = '0; in_last = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // single scalar bit
        base = evt_cnt;
        send_seg(1, 8'hA, 1, 0, 0, 1);
        drain();
        chk("scalar_events", evt_cnt - base, 1);

        // three chained segments back-to-back
        do_reset(2);
        base = evt_cnt;
        send_seg(1, 1, 1, 0, 0, 0);
        send_seg(1, 1, 2, 4, 4, 0);
        send_seg(1, 1, 5, 15, 0, 1);
        drain();
        chk("chain_events", evt_cnt - base, 18);
`ifdef PIN_RECORD_DECODER_STATS_EN
        chk("stat_seg_cnt", stat_seg_cnt, 3);
        chk("stat_bit_cnt", stat_bit_cnt, 18);
`endif

        // ascending range
        base = evt_cnt;
        send_seg(2, 3, 7, 0, 7, 1);
        drain();
        chk("ascend_events", evt_cnt - base, 8);

        // descending range under a stalling sink
        rdy_mode = 2;
        base = evt_cnt;
        send_seg(2, 3, 7, 7, 0, 1);
        drain();
        chk("stall_events", evt_cnt - base, 8);
        rdy_mode = 0;

        // reset in the middle of an expansion
        base = evt_cnt;
        send_seg(3, 4, 5, 15, 0, 1);
        guard = 0;
        while (evt_cnt < base + 3 && guard < 100) begin step(); guard++; end
        chk("mid_reset_reach3", evt_cnt >= base + 3, 1);
        rst_n = 1'b0;
        step();
        step();
        chk("mid_reset_valid", out_valid, 0);
        rst_n = 1'b1;
        step();
        chk("post_reset_quiet", out_valid, 0);
        base = evt_cnt;
        send_seg(3, 4, 6, 3, 0, 1);
        drain();
        chk("post_reset_events", evt_cnt - base, 4);

        // long chain to wrap the port-bit counter
        rdy_mode = 1;
        base = evt_cnt;
        for (int k = 0; k < 20; k++) send_seg(4, 5, 100 + k, 15, 0, 0);
        send_seg(4, 5, 200, 0, 0, 1);
        drain();
        chk("wrap_events", evt_cnt - base, 321);

        // randomized segments, gaps and sink behaviour
        base = 0;
        for (int k = 0; k < 300; k++) begin
            int msb, lsb;
            rdy_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 15) == 0) begin msb = 255; lsb = 248; end
            else begin msb = $urandom_range(0, 23); lsb = $urandom_range(0, 23); end
            base += ((msb > lsb) ? msb - lsb : lsb - msb) + 1;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
            send_seg($urandom_range(0, 65535), $urandom_range(0, 255), $urandom_range(0, 65535),
                     msb, lsb, ($urandom_range(0, 3) == 0));
        end
        drain();
        rdy_mode = 0;
        chk("random_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pin_record_decoder.md
PIN_RECORD_DECODER -- requirements
Module: pin_record_decoder

Interface
REQ-001 Parameter INST_W, default 16, instance-id width.
REQ-002 Parameter PORT_W, default 8, port-id width.
REQ-003 Parameter NET_W, default 16, net-id width.
REQ-004 Parameter BIT_W, default 8, bit-index width (net bit and port bit).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 in_valid  in  1  segment record valid.
REQ-008 in_ready  out  1  segment record accepted when in_valid&&in_ready.
REQ-009 in_inst / in_port / in_net  in  INST_W / PORT_W / NET_W  connection owner and net.
REQ-010 in_msb / in_lsb  in  BIT_W each  net range; a scalar net is msb=lsb=0.
REQ-011 in_last  in  1  final segment of this port connection (concatenation end).
REQ-012 out_valid  out  1  per-bit pin event valid.
REQ-013 out_ready  in  1  downstream accepts event when out_valid&&out_ready.
REQ-014 out_inst / out_port / out_net  out  INST_W / PORT_W / NET_W  copied from the segment.
REQ-015 out_nbit / out_pbit  out  BIT_W each  net bit index; port connection-order index.
REQ-016 out_last  out  1  last bit of the last segment of the port connection.

Function
REQ-017 The block SHALL expand each accepted range segment into one pin event per net bit, every bit exactly once, none dropped or duplicated.
REQ-018 Emission order SHALL be msb first, stepping toward lsb: step -1 if msb>lsb, +1 if msb<lsb, single event if equal.
REQ-019 out_pbit SHALL start at 0 on the first bit of a port connection, increment by 1 per emitted event, and reset to 0 after the event with out_last=1.
REQ-020 FSM states IDLE and EXPAND; IDLE->EXPAND on input handshake; EXPAND->IDLE on the final-bit output handshake when no new segment is accepted in the same cycle.
REQ-021 in_ready SHALL be 1 in IDLE, and in EXPAND only while the current event is the segment's final bit and out_ready=1 (back-to-back segments, zero bubbles).
REQ-022 The first event of an accepted segment SHALL appear on out_valid the cycle after the input handshake (latency 1); sustained throughput is 1 event/cycle.
REQ-023 While out_valid=1 and out_ready=0, every output field SHALL hold stable.
REQ-024 out_last SHALL equal in_last of the segment AND (current bit is the segment's final bit); it is 0 otherwise.
REQ-025 out_pbit wrap at 2^BIT_W SHALL be modulo, with no stall.
REQ-026 Segments with in_last=0 SHALL chain port bits; inst/port changes without an intervening in_last are passed through unchecked.

Reset
REQ-027 With rst_n=0 at a clock edge: state=IDLE, out_valid=0, out_last=0, pbit counter=0, all out_* data fields=0, and in_ready=0 during the reset cycle.
REQ-028 Reset mid-EXPAND SHALL discard the remaining bits of the segment; no event is emitted after release until a new segment is accepted.

Configuration
REQ-029 Macro PIN_RECORD_DECODER_STATS_EN: when defined, add outputs stat_seg_cnt[31:0] (accepted segments) and stat_bit_cnt[31:0] (emitted events), both cleared by reset, saturating at all-ones; when undefined, those ports and counters do not exist and all other behaviour is identical.

Structure
REQ-030 Package pin_record_pkg SHALL hold the default width constants, a seg_rec_t struct (inst, port, net, msb, lsb, last) and a pin_evt_t struct (inst, port, net, nbit, pbit, last).
REQ-031 The design SHALL be a single module with no sub-modules; the range stepper is inline.

Verification
REQ-032 Segment {inst 1, port A, net n1, 0:0, last=1}, out_ready=1 -> one event nbit=0, pbit=0, last=1, one cycle after accept.
REQ-033 Segments {n1 0:0, last=0}, {n2 4:4, last=0}, {n5 15:0, last=1} back-to-back, out_ready=1 -> 18 consecutive events, pbit 0..17, n5 nbit 15..0, out_last only on pbit 17, no idle cycles.
REQ-034 Segment {n7 0:7, last=1} -> nbit 0,1,..,7 ascending, 8 events.
REQ-035 Segment {n7 7:0}, out_ready toggling 1,0,0,1,... -> exactly 8 events, fields stable while stalled, in_ready=0 until the final bit is accepted.
REQ-036 Assert rst_n=0 after the 3rd event of {n5 15:0} -> out_valid=0 the next cycle; the next segment starts at pbit=0.
REQ-037 With PIN_RECORD_DECODER_STATS_EN defined, the REQ-033 stimulus -> stat_seg_cnt=3, stat_bit_cnt=18.
